// File: rtl/out_bcd_display_if.sv
// Bus-side signals of the OUT unit: the load strobe and data from the CPU bus,
// and the latched value and BCD conversion status going back out.
interface out_bcd_display_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  mclk_en;
   logic                  i_load_enable;
   logic [WIDTH-1:0]      i_load_data;
   logic [WIDTH-1:0]      o_data;
   logic                  o_busy;
   logic [4*DIGITS-1:0]   o_bcd;
   logic                  o_bcd_valid;

   // CPU / bus side
   modport master (
      output mclk_en, i_load_enable, i_load_data,
      input  o_data, o_busy, o_bcd, o_bcd_valid
   );

   // OUT unit side
   modport slave (
      input  mclk_en, i_load_enable, i_load_data,
      output o_data, o_busy, o_bcd, o_bcd_valid
   );
endinterface

// File: rtl/out_bcd_display.sv
// OUT register with binary-to-BCD conversion and a multiplexed 7-segment driver.
// A bus load latches the value, an iterative double-dabble engine converts it
// (one shift per mclk, WIDTH cycles), and a scan counter walks the digits with
// leading-zero blanking.
// Optional: define OUT_SIGNED_EN to treat the bus value as two's complement;
// the magnitude is converted, o_neg is added and a '-' is drawn just above the
// most significant shown digit.
module out_bcd_display #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 1024
) (
   input  logic                mclk,
   input  logic                i_reset,
   out_bcd_display_if.slave    bus,
   output logic [DIGITS-1:0]   o_an,
   output logic [6:0]          o_seg
`ifdef OUT_SIGNED_EN
   ,
   output logic                o_neg
`endif
);

   localparam int BW  = 4 * DIGITS;
   localparam int SW  = BW + WIDTH;
   localparam int CW  = $clog2(WIDTH + 1);
   localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef OUT_SIGNED_EN
   localparam int NEED = WIDTH + (WIDTH + 2) / 3 + 4;
`else
   localparam int NEED = WIDTH + (WIDTH + 2) / 3;
`endif

   // The BCD field must hold the largest converted value (plus a sign slot
   // when signed); refuse to build otherwise.
   generate
      if (BW < NEED) begin : g_digits_too_small
         $error("out_bcd_display: DIGITS too small for WIDTH");
      end
      if (SCAN_DIV < 1) begin : g_bad_scan_div
         $error("out_bcd_display: SCAN_DIV must be >= 1");
      end
   endgenerate

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t            state;
   logic [SW-1:0]     sr;
   logic [SW-1:0]     sr_adj;
   logic [SW-1:0]     sr_next;
   logic [CW-1:0]     bit_cnt;
   logic [WIDTH-1:0]  load_mag;
   logic              load;
`ifdef OUT_SIGNED_EN
   logic              neg_pend;
`endif

   assign load = bus.mclk_en & bus.i_load_enable;

`ifdef OUT_SIGNED_EN
   // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1)
   // which still fits unsigned in WIDTH bits.
   always_comb begin
      load_mag = bus.i_load_data;
      if (bus.i_load_data[WIDTH-1])
         load_mag = ~bus.i_load_data + 1'b1;
   end
`else
   assign load_mag = bus.i_load_data;
`endif

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift.
   always_comb begin
      sr_adj = sr;
      for (int i = 0; i < DIGITS; i++) begin
         if (sr[WIDTH + 4*i +: 4] >= 4'd5)
            sr_adj[WIDTH + 4*i +: 4] = sr[WIDTH + 4*i +: 4] + 4'd3;
      end
      sr_next = sr_adj << 1;
   end

   // Conversion FSM; a load always wins and restarts, dropping any result in flight.
   always_ff @(posedge mclk) begin
      if (i_reset) begin
         state           <= IDLE;
         sr              <= '0;
         bit_cnt         <= '0;
         bus.o_data      <= '0;
         bus.o_bcd       <= '0;
         bus.o_bcd_valid <= 1'b1;
         bus.o_busy      <= 1'b0;
`ifdef OUT_SIGNED_EN
         neg_pend        <= 1'b0;
         o_neg           <= 1'b0;
`endif
      end else if (load) begin
         state           <= CONVERT;
         sr              <= {{BW{1'b0}}, load_mag};
         bit_cnt         <= '0;
         bus.o_data      <= bus.i_load_data;
         bus.o_bcd_valid <= 1'b0;
         bus.o_busy      <= 1'b1;
`ifdef OUT_SIGNED_EN
         neg_pend        <= bus.i_load_data[WIDTH-1];
`endif
      end else if (state == CONVERT) begin
         sr      <= sr_next;
         bit_cnt <= bit_cnt + 1'b1;
         if (bit_cnt == CW'(WIDTH - 1)) begin
            state           <= IDLE;
            bus.o_bcd       <= sr_next[SW-1 -: BW];
            bus.o_bcd_valid <= 1'b1;
            bus.o_busy      <= 1'b0;
`ifdef OUT_SIGNED_EN
            o_neg           <= neg_pend;
`endif
         end
      end
   end

   // Scan control and digit decode
   logic [SCW-1:0] scan_cnt;
   logic [IW-1:0]  idx;
   logic [IW-1:0]  idx_nxt;
   logic [IW-1:0]  msd;
   logic           wrap;
   logic [3:0]     digit;
   logic [6:0]     seg_nxt;

   function automatic logic [6:0] dec7(input logic [3:0] d);
      case (d)
         4'd0: dec7 = 7'h3F;
         4'd1: dec7 = 7'h06;
         4'd2: dec7 = 7'h5B;
         4'd3: dec7 = 7'h4F;
         4'd4: dec7 = 7'h66;
         4'd5: dec7 = 7'h6D;
         4'd6: dec7 = 7'h7D;
         4'd7: dec7 = 7'h07;
         4'd8: dec7 = 7'h7F;
         4'd9: dec7 = 7'h6F;
         default: dec7 = 7'h00;
      endcase
   endfunction

   // Next digit position and its segment pattern, blanking above the top non-zero digit.
   always_comb begin
      wrap    = (scan_cnt == SCW'(SCAN_DIV - 1));
      idx_nxt = idx;
      if (wrap)
         idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      msd = '0;
      for (int i = 1; i < DIGITS; i++) begin
         if (bus.o_bcd[4*i +: 4] != 4'd0)
            msd = IW'(i);
      end
      digit   = bus.o_bcd[4*idx_nxt +: 4];
      seg_nxt = dec7(digit);
      if (idx_nxt > msd)
         seg_nxt = 7'h00;
`ifdef OUT_SIGNED_EN
      if (o_neg && (int'(idx_nxt) == int'(msd) + 1))
         seg_nxt = 7'h40;
`endif
   end

   // Free-running scan; o_an and o_seg are registered on the same edge.
   always_ff @(posedge mclk) begin
      if (i_reset) begin
         scan_cnt <= '0;
         idx      <= '0;
         o_an     <= DIGITS'(1);
         o_seg    <= 7'h3F;
      end else begin
         scan_cnt <= wrap ? '0 : scan_cnt + 1'b1;
         idx      <= idx_nxt;
         o_an     <= DIGITS'(1) << idx_nxt;
         o_seg    <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_out_bcd_display.sv
module tb_out_bcd_display;
   localparam int WIDTH    = 8;
`ifdef OUT_SIGNED_EN
   localparam int DIGITS   = 4;
`else
   localparam int DIGITS   = 3;
`endif
   localparam int SCAN_DIV = 4;

   logic              mclk = 1'b0;
   logic              i_reset = 1'b1;
   logic [DIGITS-1:0] o_an;
   logic [6:0]        o_seg;
`ifdef OUT_SIGNED_EN
   logic              o_neg;
`endif

   out_bcd_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   out_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .mclk    (mclk),
      .i_reset (i_reset),
      .bus     (bus),
      .o_an    (o_an),
      .o_seg   (o_seg)
`ifdef OUT_SIGNED_EN
      ,
      .o_neg   (o_neg)
`endif
   );

   always #5 mclk = ~mclk;

   int edge_cnt = 0;
   always @(posedge mclk) edge_cnt++;

   typedef struct { int val; bit neg; int due; } exp_t;
   exp_t q[$];

   int checks = 0, failures = 0;
   int m_data = 0, disp_val = 0, disp_edge = 1, rst_edge = 1;
   bit disp_neg = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   function automatic int to_bcd(input int v);
      int r = 0;
      for (int i = 0; i < DIGITS; i++) r |= ((v / (10 ** i)) % 10) << (4 * i);
      return r;
   endfunction

   function automatic logic [6:0] exp_seg(input int v, input bit neg, input int pos);
      logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      int nd = 1;
      while (nd < DIGITS && v >= 10 ** nd) nd++;
      if (pos < nd) return tbl[(v / (10 ** pos)) % 10];
      if (neg && pos == nd) return 7'h40;
      return 7'h00;
   endfunction

   // Monitor: checks the DUT state after every edge against the model.
   always @(negedge mclk) begin
      if (edge_cnt > 0) begin
         if (i_reset) begin
            check("rst_data",  bus.o_data, 0);
            check("rst_bcd",   bus.o_bcd, 0);
            check("rst_valid", bus.o_bcd_valid, 1);
            check("rst_busy",  bus.o_busy, 0);
            check("rst_an",    o_an, 1);
            check("rst_seg",   o_seg, 7'h3F);
`ifdef OUT_SIGNED_EN
            check("rst_neg",   o_neg, 0);
`endif
         end else begin
            bit exp_busy;
            int idx;
            exp_busy = (q.size() != 0);
            if (q.size() != 0 && q[0].due == edge_cnt) begin
               exp_t e;
               e = q.pop_front();
               disp_val  = e.val;
               disp_neg  = e.neg;
               disp_edge = edge_cnt;
               exp_busy  = 0;
            end
            check("busy",  bus.o_busy, exp_busy);
            check("valid", bus.o_bcd_valid, !exp_busy);
            check("bcd",   bus.o_bcd, to_bcd(disp_val));
            check("data",  bus.o_data, m_data);
`ifdef OUT_SIGNED_EN
            check("neg",   o_neg, disp_neg);
`endif
            idx = ((edge_cnt - rst_edge) / SCAN_DIV) % DIGITS;
            check("an", o_an, 1 << idx);
            if (edge_cnt > disp_edge)
               check("seg", o_seg, exp_seg(disp_val, disp_neg, idx));
         end
      end
   end

   // One cycle of stimulus; the model is updated for the edge about to come.
   task automatic drive(input bit rst, input bit en, input bit le, input int data);
      @(negedge mclk);
      #1;
      i_reset           = rst;
      bus.mclk_en       = en;
      bus.i_load_enable = le;
      bus.i_load_data   = WIDTH'(data);
      if (rst) begin
         q.delete();
         m_data    = 0;
         disp_val  = 0;
         disp_neg  = 0;
         rst_edge  = edge_cnt + 1;
         disp_edge = edge_cnt + 1;
      end else if (en && le) begin
         int d, mag;
         bit neg;
         d = data & ((1 << WIDTH) - 1);
`ifdef OUT_SIGNED_EN
         neg = (d >= (1 << (WIDTH - 1)));
         mag = neg ? (1 << WIDTH) - d : d;
`else
         neg = 0;
         mag = d;
`endif
         m_data = d;
         q.delete();
         q.push_back('{val: mag, neg: neg, due: edge_cnt + 1 + WIDTH});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, $urandom_range(0, 1), 0, $urandom);
   endtask

   initial begin
      bus.mclk_en = 0;
      bus.i_load_enable = 0;
      bus.i_load_data = '0;
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(0, 1, 1, 255);          // full-scale value
      idle(10);
      drive(0, 0, 1, 99);           // load without CPU enable: ignored
      idle(3);
      drive(0, 1, 1, 200);          // restarted before it completes
      idle(2);
      drive(0, 1, 1, 7);
      idle(30);                     // watch a full scan rotation on 007
      drive(0, 1, 1, 128);
      idle(3);
      drive(1, 0, 0, 0);            // reset mid-conversion
      idle(5);
      drive(0, 1, 1, 50);
      idle(WIDTH - 1);
      drive(0, 1, 1, 60);           // load on the completion edge of 50
      idle(12);
      drive(0, 1, 1, 8'hF9);
      idle(14);
      drive(0, 1, 1, 8'h80);
      idle(14);
      drive(0, 1, 1, 0);
      idle(12);
      for (int i = 0; i < 500; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 2)       drive(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
         else if (r < 12) drive(0, 1, 1, $urandom);
         else if (r < 18) drive(0, 0, 1, $urandom);
         else             drive(0, $urandom_range(0, 1), 0, $urandom);
      end
      idle(20);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
